router_ctrl_fsm: RTL and testbench

// - Control sequencer for the 1x3 router: walks the input packet register through its phases (header, payload, full-stall, parity).
// - Latches the packet destination (data_in[1:0]), selects the target output FIFO, gates its write enable and muxes its full flag.
// - Runs per-port read timeouts that soft-reset a FIFO whose data is not drained in time. Sits between the input port and the register/FIFO datapath.

---
 rtl/router_pkg.sv | 19 +
 rtl/router_timeout_ctr.sv | 34 +++
 rtl/router_ctrl_fsm.sv | 111 +++++++++++
 tb/tb_router_ctrl_fsm.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router control path.
package router_pkg;

    localparam int          NPORTS       = 3;
    localparam int          TIMEOUT_DEF  = 30;
    localparam logic [1:0]  ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

endpackage

// File: rtl/router_timeout_ctr.sv
// One output port's read-timeout counter; emits a single-cycle soft_reset
// once data has sat unread for TIMEOUT consecutive cycles.
module router_timeout_ctr #(
    parameter int TIMEOUT = 30
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_vld,
    input  logic i_rd,
    output logic o_soft_reset
);

    localparam int              CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt        <= '0;
            o_soft_reset <= 1'b0;
        end else if (!i_vld || i_rd) begin
            r_cnt        <= '0;
            o_soft_reset <= 1'b0;
        end else if (r_cnt == LAST) begin
            r_cnt        <= '0;
            o_soft_reset <= 1'b1;
        end else begin
            r_cnt        <= r_cnt + 1'b1;
            o_soft_reset <= 1'b0;
        end
    end

endmodule

// File: rtl/router_ctrl_fsm.sv
// Router control sequencer: packet phase FSM, destination latch, FIFO
// write/full steering and per-port read timeouts.
module router_ctrl_fsm
    import router_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pkt_valid,
    input  logic [1:0]        data_in,
    input  logic [NPORTS-1:0] fifo_full_in,
    input  logic [NPORTS-1:0] fifo_empty,
    input  logic [NPORTS-1:0] read_enb,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              rst_int_reg,
    output logic              write_enb_reg,
    output logic              busy,
    output logic              fifo_full,
    output logic [NPORTS-1:0] write_enb,
    output logic [NPORTS-1:0] vld_out,
    output logic [NPORTS-1:0] soft_reset
);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_addr;
    logic       w_addr_ok;

    assign w_addr_ok = (data_in != ADDR_INVALID);
    assign fifo_full = fifo_full_in[r_addr];
    assign write_enb = write_enb_reg ? (3'b001 << r_addr) : 3'b000;
    assign vld_out   = ~fifo_empty;

    always_comb begin
        w_next = r_state;
        case (r_state)
            DECODE_ADDRESS:
                if (pkt_valid && w_addr_ok)
                    w_next = fifo_empty[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            LOAD_FIRST_DATA:
                w_next = LOAD_DATA;
            LOAD_DATA:
                if (fifo_full)       w_next = FIFO_FULL_STATE;
                else if (!pkt_valid) w_next = LOAD_PARITY;
            FIFO_FULL_STATE:
                if (!fifo_full)      w_next = LOAD_AFTER_FULL;
            LOAD_AFTER_FULL:
                if (parity_done)        w_next = DECODE_ADDRESS;
                else if (low_pkt_valid) w_next = LOAD_PARITY;
                else                    w_next = LOAD_DATA;
            LOAD_PARITY:
                w_next = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR:
                w_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            WAIT_TILL_EMPTY:
                if (fifo_empty[r_addr]) w_next = LOAD_FIRST_DATA;
            default:
                w_next = DECODE_ADDRESS;
        endcase
        // A flushed destination abandons whatever packet was in flight.
        if (r_state != DECODE_ADDRESS && soft_reset[r_addr])
            w_next = DECODE_ADDRESS;
    end

    // State decodes are registered from the next state so they align with r_state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= DECODE_ADDRESS;
            r_addr        <= 2'b00;
            detect_add    <= 1'b1;
            lfd_state     <= 1'b0;
            ld_state      <= 1'b0;
            laf_state     <= 1'b0;
            full_state    <= 1'b0;
            rst_int_reg   <= 1'b0;
            write_enb_reg <= 1'b0;
            busy          <= 1'b0;
        end else begin
            r_state       <= w_next;
            if (detect_add && pkt_valid && w_addr_ok)
                r_addr <= data_in;
            detect_add    <= (w_next == DECODE_ADDRESS);
            lfd_state     <= (w_next == LOAD_FIRST_DATA);
            ld_state      <= (w_next == LOAD_DATA);
            laf_state     <= (w_next == LOAD_AFTER_FULL);
            full_state    <= (w_next == FIFO_FULL_STATE);
            rst_int_reg   <= (w_next == CHECK_PARITY_ERROR);
            write_enb_reg <= (w_next inside {LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL});
            busy          <= (w_next inside {LOAD_FIRST_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL,
                                             LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY});
        end
    end

    for (genvar g = 0; g < NPORTS; g++) begin : g_to
        router_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_to (
            .i_clk        (clk),
            .i_reset      (reset),
            .i_vld        (vld_out[g]),
            .i_rd         (read_enb[g]),
            .o_soft_reset (soft_reset[g])
        );
    end

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Scenario tests plus randomized run against a packet-level reference model.
module tb_router_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pkt_valid = 1'b0;
    logic [1:0] data_in = 2'b00;
    logic [2:0] fifo_full_in = 3'b000;
    logic [2:0] fifo_empty = 3'b111;
    logic [2:0] read_enb = 3'b000;
    logic       parity_done = 1'b0;
    logic       low_pkt_valid = 1'b0;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
    logic       write_enb_reg, busy, fifo_full;
    logic [2:0] write_enb, vld_out, soft_reset;

    int checks = 0;
    int failures = 0;

    router_ctrl_fsm dut (
        .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full_in(fifo_full_in), .fifo_empty(fifo_empty), .read_enb(read_enb),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
        .write_enb_reg(write_enb_reg), .busy(busy), .fifo_full(fifo_full),
        .write_enb(write_enb), .vld_out(vld_out), .soft_reset(soft_reset)
    );

    always #5 clk = ~clk;

    // Reference model: packet phase, latched destination, length of each port's unread run.
    typedef enum int {M_DEC, M_LFD, M_LD, M_FFS, M_LAF, M_LP, M_CPE, M_WTE} mphase_t;
    mphase_t    m_ph = M_DEC;
    int         m_addr = 0;
    int         m_stall [3] = '{0, 0, 0};
    logic [2:0] m_soft = 3'b000;

    task automatic model_update();
        mphase_t nx;
        logic    full;
        if (reset) begin
            m_ph = M_DEC; m_addr = 0; m_soft = 3'b000;
            for (int i = 0; i < 3; i++) m_stall[i] = 0;
        end else begin
            full = fifo_full_in[m_addr];
            nx = m_ph;
            case (m_ph)
                M_DEC: if (pkt_valid && data_in != 2'b11) nx = fifo_empty[data_in] ? M_LFD : M_WTE;
                M_LFD: nx = M_LD;
                M_LD:  nx = full ? M_FFS : (!pkt_valid ? M_LP : M_LD);
                M_FFS: nx = full ? M_FFS : M_LAF;
                M_LAF: nx = parity_done ? M_DEC : (low_pkt_valid ? M_LP : M_LD);
                M_LP:  nx = M_CPE;
                M_CPE: nx = full ? M_FFS : M_DEC;
                M_WTE: nx = fifo_empty[m_addr] ? M_LFD : M_WTE;
                default: nx = M_DEC;
            endcase
            if (m_ph != M_DEC && m_soft[m_addr]) nx = M_DEC;
            if (m_ph == M_DEC && pkt_valid && data_in != 2'b11) m_addr = int'(data_in);
            for (int i = 0; i < 3; i++) begin
                if (!fifo_empty[i] && !read_enb[i]) m_stall[i]++;
                else m_stall[i] = 0;
                m_soft[i] = (m_stall[i] > 0) && (m_stall[i] % 30 == 0);
            end
            m_ph = nx;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        checks++;
        if ({detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, write_enb_reg, busy} !== 8'b1000_0000) begin
            failures++; $display("FAIL reset_decodes got=%b exp=10000000",
                {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, write_enb_reg, busy});
        end
        checks++;
        if ({write_enb, soft_reset} !== 6'b0) begin
            failures++; $display("FAIL reset_we_soft got=%b exp=000000", {write_enb, soft_reset});
        end
        reset = 1'b0;
    endtask

    task automatic test_basic_packet();
        pkt_valid = 1'b1; data_in = 2'b01; fifo_empty = 3'b111;
        step();
        checks++;
        if (!(lfd_state === 1'b1 && busy === 1'b1)) begin
            failures++; $display("FAIL basic_lfd got lfd=%b busy=%b exp 1 1", lfd_state, busy);
        end
        step();
        checks++;
        if (!(ld_state === 1'b1 && write_enb === 3'b010 && busy === 1'b0)) begin
            failures++; $display("FAIL basic_ld got ld=%b we=%b busy=%b exp 1 010 0", ld_state, write_enb, busy);
        end
        pkt_valid = 1'b0;
        step();
        checks++;
        if (!(write_enb_reg === 1'b1 && busy === 1'b1 && ld_state === 1'b0 && detect_add === 1'b0)) begin
            failures++; $display("FAIL basic_lp got wer=%b busy=%b ld=%b exp 1 1 0", write_enb_reg, busy, ld_state);
        end
        step();
        checks++;
        if (!(rst_int_reg === 1'b1 && write_enb === 3'b000)) begin
            failures++; $display("FAIL basic_cpe got rst_int=%b we=%b exp 1 000", rst_int_reg, write_enb);
        end
        step();
        checks++;
        if (!(detect_add === 1'b1 && busy === 1'b0)) begin
            failures++; $display("FAIL basic_dec got detect=%b busy=%b exp 1 0", detect_add, busy);
        end
    endtask

    task automatic test_invalid_addr();
        logic bad = 1'b0;
        fifo_full_in = 3'b010; pkt_valid = 1'b1; data_in = 2'b11;
        for (int k = 0; k < 5; k++) begin
            step();
            if (!(detect_add === 1'b1 && busy === 1'b0 && write_enb === 3'b000)) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++; $display("FAIL invalid_addr_stay got detect=%b busy=%b we=%b exp 1 0 000", detect_add, busy, write_enb);
        end
        checks++;
        if (fifo_full !== 1'b1) begin
            failures++; $display("FAIL invalid_addr_held got fifo_full=%b exp 1", fifo_full);
        end
        fifo_full_in = 3'b101; #1;
        checks++;
        if (fifo_full !== 1'b0) begin
            failures++; $display("FAIL invalid_addr_mux got fifo_full=%b exp 0", fifo_full);
        end
        pkt_valid = 1'b0; data_in = 2'b00; fifo_full_in = 3'b000;
    endtask

    task automatic test_wait_empty();
        logic bad = 1'b0;
        fifo_empty = 3'b011; read_enb = 3'b111; pkt_valid = 1'b1; data_in = 2'b10;
        step();
        checks++;
        if (!(busy === 1'b1 && detect_add === 1'b0 && lfd_state === 1'b0 && vld_out === 3'b100)) begin
            failures++; $display("FAIL wte_enter got busy=%b detect=%b lfd=%b vld=%b exp 1 0 0 100", busy, detect_add, lfd_state, vld_out);
        end
        pkt_valid = 1'b0; data_in = 2'b00;
        for (int k = 0; k < 3; k++) begin
            step();
            if (!(busy === 1'b1 && lfd_state === 1'b0)) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++; $display("FAIL wte_hold got busy=%b lfd=%b exp 1 0", busy, lfd_state);
        end
        fifo_empty = 3'b111;
        step();
        checks++;
        if (lfd_state !== 1'b1) begin
            failures++; $display("FAIL wte_release got lfd=%b exp 1", lfd_state);
        end
        step();
        checks++;
        if (!(ld_state === 1'b1 && write_enb === 3'b100)) begin
            failures++; $display("FAIL wte_ld got ld=%b we=%b exp 1 100", ld_state, write_enb);
        end
        step(); step(); step();
        checks++;
        if (detect_add !== 1'b1) begin
            failures++; $display("FAIL wte_done got detect=%b exp 1", detect_add);
        end
        read_enb = 3'b000;
    endtask

    task automatic test_full_stall();
        pkt_valid = 1'b1; data_in = 2'b00;
        step(); step();
        checks++;
        if (!(ld_state === 1'b1 && write_enb === 3'b001)) begin
            failures++; $display("FAIL full_ld got ld=%b we=%b exp 1 001", ld_state, write_enb);
        end
        fifo_full_in = 3'b001; #1;
        checks++;
        if (fifo_full !== 1'b1) begin
            failures++; $display("FAIL full_mux got fifo_full=%b exp 1", fifo_full);
        end
        step(); step();
        checks++;
        if (!(full_state === 1'b1 && busy === 1'b1 && write_enb === 3'b000)) begin
            failures++; $display("FAIL full_ffs got full=%b busy=%b we=%b exp 1 1 000", full_state, busy, write_enb);
        end
        fifo_full_in = 3'b000;
        step();
        checks++;
        if (!(laf_state === 1'b1 && busy === 1'b1 && write_enb === 3'b001)) begin
            failures++; $display("FAIL full_laf got laf=%b busy=%b we=%b exp 1 1 001", laf_state, busy, write_enb);
        end
        low_pkt_valid = 1'b1; parity_done = 1'b0;
        step();
        checks++;
        if (!(laf_state === 1'b0 && write_enb_reg === 1'b1 && busy === 1'b1 && ld_state === 1'b0)) begin
            failures++; $display("FAIL full_laf_to_lp got laf=%b wer=%b busy=%b ld=%b exp 0 1 1 0", laf_state, write_enb_reg, busy, ld_state);
        end
        low_pkt_valid = 1'b0; pkt_valid = 1'b0;
        step(); step();
        checks++;
        if (detect_add !== 1'b1) begin
            failures++; $display("FAIL full_first_done got detect=%b exp 1", detect_add);
        end
        pkt_valid = 1'b1; data_in = 2'b00;
        step(); step();
        fifo_full_in = 3'b001;
        step();
        fifo_full_in = 3'b000;
        step();
        pkt_valid = 1'b0; parity_done = 1'b1;
        step();
        checks++;
        if (!(detect_add === 1'b1 && write_enb === 3'b000)) begin
            failures++; $display("FAIL full_laf_parity_done got detect=%b we=%b exp 1 000", detect_add, write_enb);
        end
        parity_done = 1'b0;
    endtask

    task automatic test_timeout();
        logic bad = 1'b0;
        pkt_valid = 1'b1; data_in = 2'b01; fifo_empty = 3'b111; read_enb = 3'b000;
        step(); step();
        fifo_empty = 3'b101;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (k < 30 && (soft_reset !== 3'b000 || ld_state !== 1'b1)) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++; $display("FAIL timeout_early got soft=%b ld=%b exp 000 1", soft_reset, ld_state);
        end
        checks++;
        if (!(soft_reset === 3'b010 && ld_state === 1'b1)) begin
            failures++; $display("FAIL timeout_pulse got soft=%b ld=%b exp 010 1", soft_reset, ld_state);
        end
        pkt_valid = 1'b0;
        step();
        checks++;
        if (!(soft_reset === 3'b000 && detect_add === 1'b1 && write_enb === 3'b000)) begin
            failures++; $display("FAIL timeout_abort got soft=%b detect=%b we=%b exp 000 1 000", soft_reset, detect_add, write_enb);
        end
        fifo_empty = 3'b111;
        step();
        fifo_empty = 3'b101; bad = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            read_enb = (k == 29) ? 3'b010 : 3'b000;
            step();
            if (soft_reset !== 3'b000) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++; $display("FAIL timeout_read_at_29 got soft=%b exp 000", soft_reset);
        end
        read_enb = 3'b000; fifo_empty = 3'b111;
        step();
        fifo_empty = 3'b000; bad = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (k < 30 && soft_reset !== 3'b000) bad = 1'b1;
        end
        checks++;
        if (bad || soft_reset !== 3'b111) begin
            failures++; $display("FAIL timeout_all_ports got soft=%b early=%b exp 111 0", soft_reset, bad);
        end
        fifo_empty = 3'b111;
        step();
    endtask

    task automatic test_reset_mid_packet();
        logic bad = 1'b0;
        pkt_valid = 1'b1; data_in = 2'b00; fifo_empty = 3'b111;
        step(); step();
        fifo_empty = 3'b110;
        repeat (10) step();
        checks++;
        if (!(ld_state === 1'b1 && write_enb === 3'b001)) begin
            failures++; $display("FAIL rstmid_ld got ld=%b we=%b exp 1 001", ld_state, write_enb);
        end
        reset = 1'b1;
        step();
        checks++;
        if (!(detect_add === 1'b1 && ld_state === 1'b0 && write_enb === 3'b000 && busy === 1'b0 && soft_reset === 3'b000)) begin
            failures++; $display("FAIL rstmid_state got detect=%b ld=%b we=%b busy=%b soft=%b exp 1 0 000 0 000",
                detect_add, ld_state, write_enb, busy, soft_reset);
        end
        reset = 1'b0; pkt_valid = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (k < 30 && soft_reset !== 3'b000) bad = 1'b1;
        end
        checks++;
        if (bad || soft_reset !== 3'b001) begin
            failures++; $display("FAIL rstmid_counter_cleared got soft=%b early=%b exp 001 0", soft_reset, bad);
        end
        fifo_empty = 3'b111;
        step();
    endtask

    task automatic test_random();
        logic [7:0] exp_dec, got_dec;
        logic [2:0] exp_we;
        logic       exp_wer;
        for (int n = 0; n < 2000; n++) begin
            reset         = ($urandom_range(99) == 0);
            pkt_valid     = ($urandom_range(3) != 0);
            data_in       = 2'($urandom_range(3));
            for (int i = 0; i < 3; i++) begin
                fifo_full_in[i] = ($urandom_range(4) == 0);
                fifo_empty[i]   = ($urandom_range(1) == 0);
                read_enb[i]     = ($urandom_range(7) == 0);
            end
            low_pkt_valid = ($urandom_range(3) == 0);
            parity_done   = ($urandom_range(3) == 0);
            step();
            exp_wer = (m_ph == M_LD) || (m_ph == M_LP) || (m_ph == M_LAF);
            exp_dec = {m_ph == M_DEC, m_ph == M_LFD, m_ph == M_LD, m_ph == M_LAF,
                       m_ph == M_FFS, m_ph == M_CPE, exp_wer, !(m_ph == M_DEC || m_ph == M_LD)};
            exp_we  = exp_wer ? 3'(1 << m_addr) : 3'b000;
            got_dec = {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, write_enb_reg, busy};
            checks++;
            if (got_dec !== exp_dec || write_enb !== exp_we || fifo_full !== fifo_full_in[m_addr] ||
                vld_out !== ~fifo_empty || soft_reset !== m_soft) begin
                failures++;
                $display("FAIL random cyc=%0d got dec=%b we=%b full=%b vld=%b soft=%b exp dec=%b we=%b full=%b vld=%b soft=%b",
                    n, got_dec, write_enb, fifo_full, vld_out, soft_reset,
                    exp_dec, exp_we, fifo_full_in[m_addr], ~fifo_empty, m_soft);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_packet();
        test_invalid_addr();
        test_wait_empty();
        test_full_stall();
        test_timeout();
        test_reset_mid_packet();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
